// File: rtl/seq_mul_pkg.sv
// Shared types and sizing for the sequential multiplier.
package seq_mul_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? unsigned'($clog2(w)) : 1;
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/Busy/Done handshake and operand/product bus of the sequential multiplier.
interface seq_multiplier_if
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);
  logic             Start;
  logic [WIDTH-1:0] InA;
  logic [WIDTH-1:0] InB;
  logic [WIDTH-1:0] Out_H;
  logic [WIDTH-1:0] Out_L;
  logic             Busy;
  logic             Done;

  modport master (output Start, InA, InB, input Out_H, Out_L, Busy, Done);
  modport slave  (input Start, InA, InB, output Out_H, Out_L, Busy, Done);
endinterface

// File: rtl/mul_addsub.sv
// Combinational add/subtract used for the per-iteration partial product.
module mul_addsub #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] res_c
);
  assign res_c = sub ? (a - b) : (a + b);
endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-and-add multiplier, one partial product per clock.
// Define SEQ_MUL_SIGNED_EN for two's complement operands via radix-2 Booth.
module seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  seq_multiplier_if.slave  bus
);
  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state, state_nx;
  logic [AW-1:0]    acc, acc_nx;
  logic [WIDTH-1:0] mcand, mcand_nx;
  logic [WIDTH-1:0] mplier, mplier_nx;
  logic [CW-1:0]    count, count_nx;
  logic [WIDTH-1:0] out_h_q, out_h_nx;
  logic [WIDTH-1:0] out_l_q, out_l_nx;
  logic             busy_q, busy_nx;
  logic             done_q, done_nx;

  logic [AW-1:0]    addend;
  logic [AW-1:0]    sum_c;
  logic [AW-1:0]    shift_src;
  logic             sub;
  logic             use_sum;
  logic             fill;

`ifdef SEQ_MUL_SIGNED_EN
  logic q_1, q_1_nx;

  // Booth recoding of the {Q[0], q_1} pair.
  always_comb begin
    use_sum = 1'b0;
    sub     = 1'b0;
    case ({mplier[0], q_1})
      2'b10:   begin use_sum = 1'b1; sub = 1'b1; end
      2'b01:   begin use_sum = 1'b1; sub = 1'b0; end
      default: begin use_sum = 1'b0; sub = 1'b0; end
    endcase
  end

  assign addend = {mcand[WIDTH-1], mcand};
  assign fill   = shift_src[AW-1];
`else
  assign use_sum = mplier[0];
  assign sub     = 1'b0;
  assign addend  = {1'b0, mcand};
  assign fill    = 1'b0;
`endif

  mul_addsub #(.W(AW)) u_addsub (
    .a     (acc),
    .b     (addend),
    .sub   (sub),
    .res_c (sum_c)
  );

  // In the unsigned build the top bit of sum_c is the carry C shifted into A.
  assign shift_src = use_sum ? sum_c : acc;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    mcand_nx  = mcand;
    mplier_nx = mplier;
    count_nx  = count;
    out_h_nx  = out_h_q;
    out_l_nx  = out_l_q;
    busy_nx   = busy_q;
    done_nx   = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
    q_1_nx    = q_1;
`endif
    case (state)
      IDLE: begin
        if (bus.Start) begin
          mcand_nx  = bus.InA;
          mplier_nx = bus.InB;
          acc_nx    = '0;
          count_nx  = '0;
`ifdef SEQ_MUL_SIGNED_EN
          q_1_nx    = 1'b0;
`endif
          busy_nx   = 1'b1;
          state_nx  = CALC;
        end
      end
      CALC: begin
        acc_nx    = {fill, shift_src[AW-1:1]};
        mplier_nx = {shift_src[0], mplier[WIDTH-1:1]};
`ifdef SEQ_MUL_SIGNED_EN
        q_1_nx    = mplier[0];
`endif
        count_nx  = count + CW'(1);
        if (count == CW'(WIDTH - 1)) state_nx = DONE;
      end
      DONE: begin
        out_h_nx = acc[WIDTH-1:0];
        out_l_nx = mplier;
        busy_nx  = 1'b0;
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      out_h_q <= '0;
      out_l_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
      q_1     <= 1'b0;
`endif
    end else begin
      acc     <= acc_nx;
      mcand   <= mcand_nx;
      mplier  <= mplier_nx;
      count   <= count_nx;
      out_h_q <= out_h_nx;
      out_l_q <= out_l_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
`ifdef SEQ_MUL_SIGNED_EN
      q_1     <= q_1_nx;
`endif
    end
  end

  assign bus.Out_H = out_h_q;
  assign bus.Out_L = out_l_q;
  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized and directed checks of seq_multiplier against an arithmetic product model.
module tb_seq_multiplier;
  import seq_mul_pkg::*;

  localparam int unsigned W       = WIDTH_DEF;
  localparam int          LATENCY = 9;

  logic clk = 1'b0;
  logic rst;

  seq_multiplier_if #(.WIDTH(W)) bus ();

  seq_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
    int p;
`ifdef SEQ_MUL_SIGNED_EN
    p = int'($signed(a)) * int'($signed(b));
`else
    p = int'(a) * int'(b);
`endif
    return p[15:0];
  endfunction

  function automatic logic [31:0] prod_now();
    return 32'({bus.Out_H, bus.Out_L});
  endfunction

  // Advance one negedge at a time until Done, counting edges since acceptance.
  task automatic wait_done(input int e0, output int e);
    bit busy_ok;
    busy_ok = 1'b1;
    e = e0;
    while (bus.Done !== 1'b1 && e < 40) begin
      if (bus.Busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      e++;
    end
    check("busy_held", 32'(busy_ok), 32'd1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                        input string tag);
    int lat;
    bus.InA   = a;
    bus.InB   = b;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    check({tag, "_busy_rise"}, 32'(bus.Busy), 32'd1);
    wait_done(0, lat);
    check({tag, "_latency"}, 32'(lat), 32'(LATENCY));
    check({tag, "_product"}, prod_now(), 32'(exp));
    check({tag, "_busy_fall"}, 32'(bus.Busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.Done), 32'd0);
    check({tag, "_hold"}, prod_now(), 32'(exp));
  endtask

  initial begin
    vec_t dir [3];
    int   lat;
    bit   done_seen;
    logic [7:0] ra, rb;

`ifdef SEQ_MUL_SIGNED_EN
    dir[0] = '{a: 8'hFD, b: 8'h05, p: 16'hFFF1};
    dir[1] = '{a: 8'h80, b: 8'h80, p: 16'h4000};
    dir[2] = '{a: 8'h7F, b: 8'h80, p: 16'hC080};
`else
    dir[0] = '{a: 8'd13,  b: 8'd11,  p: 16'h008F};
    dir[1] = '{a: 8'hFF,  b: 8'hFF,  p: 16'hFE01};
    dir[2] = '{a: 8'd0,   b: 8'd200, p: 16'h0000};
`endif

    rst       = 1'b0;
    bus.Start = 1'b0;
    bus.InA   = '0;
    bus.InB   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_out_h", 32'(bus.Out_H), 32'd0);
    check("rst_out_l", 32'(bus.Out_L), 32'd0);
    check("rst_busy",  32'(bus.Busy),  32'd0);
    check("rst_done",  32'(bus.Done),  32'd0);

    for (int i = 0; i < 3; i++) run_op(dir[i].a, dir[i].b, dir[i].p, "dir");

    // Start re-pulsed mid-operation and again during DONE must be ignored.
    bus.InA   = 8'd7;
    bus.InB   = 8'd9;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (2) @(negedge clk);
    bus.InA   = 8'd2;
    bus.InB   = 8'd2;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (5) @(negedge clk);
    bus.Start = 1'b1;
    @(negedge clk);
    check("ign_done",    32'(bus.Done), 32'd1);
    check("ign_product", prod_now(),    32'h003F);
    @(negedge clk);
    bus.Start = 1'b0;
    check("b2b_busy", 32'(bus.Busy), 32'd1);
    check("b2b_done", 32'(bus.Done), 32'd0);
    wait_done(0, lat);
    check("b2b_latency", 32'(lat),   32'(LATENCY));
    check("b2b_product", prod_now(), 32'h0004);
    @(negedge clk);

    // Reset mid-operation aborts with no result and no Done.
    bus.InA   = 8'd100;
    bus.InB   = 8'd100;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_h", 32'(bus.Out_H), 32'd0);
    check("abort_out_l", 32'(bus.Out_L), 32'd0);
    check("abort_busy",  32'(bus.Busy),  32'd0);
    check("abort_done",  32'(bus.Done),  32'd0);
    rst = 1'b1;
    done_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.Done === 1'b1) done_seen = 1'b1;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_idle",    32'(bus.Busy),  32'd0);
    check("abort_result",  prod_now(),     32'd0);
    run_op(8'd5, 8'd6, 16'h001E, "post_rst");

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, ref_prod(ra, rb), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
